// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches the execute-stage result for MEM, honours the
// stall-controller advance/hold/bubble contract plus flush, and counts inserted bubbles.
module ex_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 2,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3,
  parameter int PERF_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [PC_W-1:0]       ex_pc,
  input  logic [ADDR_W-1:0]     ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [CNT_W-1:0]      cnt_i,
  input  logic [2*DATA_W-1:0]   hilo_i,
  output logic                  mem_valid,
  output logic [PC_W-1:0]       mem_pc,
  output logic [ADDR_W-1:0]     mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [PERF_W-1:0]     bubble_cnt
);

  localparam int MEM_IDX = STAGE_IDX + 1;

  typedef enum logic [2:0] {
    M_RESET,
    M_FLUSH,
    M_BUBBLE,
    M_HOLD,
    M_ADVANCE
  } mode_t;

  mode_t mode;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

  // EX stall low with MEM stall high is an illegal request and still advances.
  always_comb begin
    mode = M_ADVANCE;
    if (rst)
      mode = M_RESET;
    else if (flush)
      mode = M_FLUSH;
    else if (stall[STAGE_IDX])
      mode = stall[MEM_IDX] ? M_HOLD : M_BUBBLE;
  end

  // EX -> MEM register boundary
  always_ff @(posedge clk) begin
    case (mode)
      M_RESET, M_FLUSH, M_BUBBLE: begin
        mem_valid <= 1'b0;
        mem_pc    <= '0;
        mem_wd    <= '0;
        mem_wreg  <= 1'b0;
        mem_wdata <= '0;
        mem_whilo <= 1'b0;
        mem_hi    <= '0;
        mem_lo    <= '0;
      end
      M_ADVANCE: begin
        mem_valid <= ex_valid;
        mem_pc    <= ex_pc;
        mem_wd    <= ex_wd;
        mem_wreg  <= ex_wreg;
        mem_wdata <= ex_wdata;
        mem_whilo <= ex_whilo;
        mem_hi    <= ex_hi;
        mem_lo    <= ex_lo;
      end
      default: ;
    endcase

    // The MADD/MSUB step must return to EX even while EX inserts a bubble.
    case (mode)
      M_RESET, M_FLUSH: begin
        cnt_o  <= '0;
        hilo_o <= '0;
      end
      M_BUBBLE, M_ADVANCE: begin
        cnt_o  <= cnt_i;
        hilo_o <= hilo_i;
      end
      default: ;
    endcase

    case (mode)
      M_RESET:  bubble_cnt <= '0;
      M_BUBBLE: bubble_cnt <= sat_inc(bubble_cnt);
      default:  ;
    endcase
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline register for the five-stage core. Latches the execute-stage result (GPR write-back, HI/LO write-back, instruction PC) on each rising clock edge and presents it to MEM. Implements the stall-controller contract (advance / hold / insert bubble) plus an explicit flush, and carries the two-cycle multiply-accumulate temporaries back to EX. Adds a valid bit and a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, GPR and HI/LO data width
- ADDR_W, 5, GPR address width
- PC_W, 32, instruction address width
- CNT_W, 2, multi-cycle step counter width
- STALL_W, 6, width of stall-controller vector
- STAGE_IDX, 3, bit of stall vector owned by EX; bit STAGE_IDX+1 is MEM (requires STAGE_IDX+1 < STALL_W)
- PERF_W, 16, bubble counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  stall-controller vector
- flush  in  1  discard stage contents
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  PC_W  instruction address
- ex_wd  in  ADDR_W  destination GPR
- ex_wreg  in  1  GPR write enable
- ex_wdata  in  DATA_W  GPR write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi, ex_lo  in  DATA_W each  HI/LO write data
- cnt_i  in  CNT_W  multi-cycle step from EX
- hilo_i  in  2*DATA_W  multi-cycle partial {hi,lo} from EX
- mem_valid, mem_pc, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo  out  (widths as EX counterparts)  registered MEM-side copies
- cnt_o  out  CNT_W  step fed back to EX
- hilo_o  out  2*DATA_W  partial product fed back to EX
- bubble_cnt  out  PERF_W  bubbles inserted since reset

## Operation
Mode per cycle, priority top-down:
- RESET (rst=1): all outputs 0 (mem_wd = 0 = NOP register, all enables 0, mem_valid 0, cnt_o 0, hilo_o 0, bubble_cnt 0).
- FLUSH (flush=1): payload cleared to reset values; cnt_o/hilo_o cleared; bubble_cnt unchanged.
- BUBBLE (stall[STAGE_IDX]=1, stall[STAGE_IDX+1]=0): payload cleared to reset values (mem_valid 0, enables 0); cnt_o<=cnt_i, hilo_o<=hilo_i; bubble_cnt increments, saturating at all-ones.
- HOLD (stall[STAGE_IDX]=1, stall[STAGE_IDX+1]=1): every register keeps its value.
- ADVANCE (stall[STAGE_IDX]=0): every payload output <= EX counterpart; cnt_o<=cnt_i, hilo_o<=hilo_i.
- Bubble payload is architecturally inert: no GPR or HI/LO write can result.
- cnt_o/hilo_o must update in BUBBLE: EX stalls itself for the first MADD/MSUB cycle and needs its step/partial back next cycle.
- mem_valid in ADVANCE equals ex_valid; ex_valid=0 with enables set still passes enables through (EX is responsible for clearing them).

## Timing
- Latency: exactly 1 cycle from EX input to MEM output in ADVANCE.
- No combinational path input -> output; all outputs registered.
- rst asserted mid-hold or mid-multi-cycle sequence: next edge all zeros, sequence abandoned.
- flush concurrent with any stall pattern: flush wins.
- stall[STAGE_IDX]=0 with stall[STAGE_IDX+1]=1 is illegal from the controller; block still ADVANCEs.
- bubble_cnt at 2^PERF_W-1 stays there.

## Test plan
- Reset: drive nonzero inputs, rst=1 one edge -> all outputs 0, bubble_cnt 0.
- Advance: ex_wd=5, ex_wreg=1, ex_wdata=0xDEADBEEF, ex_pc=0x100, stall=0 -> next edge mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, mem_pc=0x100, mem_valid=1.
- Bubble: stall=6'b001000 with cnt_i=1, hilo_i=0x0000000100000002 -> mem_wreg=0, mem_wd=0, mem_valid=0, cnt_o=1, hilo_o=0x0000000100000002, bubble_cnt +1.
- Hold: load payload, then stall=6'b011000 for 3 cycles with changing inputs -> all outputs unchanged, bubble_cnt unchanged.
- Flush priority: stall=6'b011000 and flush=1 -> payload, cnt_o, hilo_o all 0 next edge.
- Saturation: PERF_W=2, four consecutive bubbles -> bubble_cnt 1,2,3,3.
